// File: rtl/race_timer_pkg.sv
// Shared race definitions: FSM state encoding and lap-time width/saturation,
// common to the race timer and the downstream lap-time tracker.
package race_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_ARMED   = 2'd2,
      ST_DONE    = 2'd3
   } race_state_t;

   localparam int TIME_W = 16;
   localparam logic [TIME_W-1:0] TIME_SAT = {TIME_W{1'b1}};

   // Increment that sticks at TIME_SAT instead of wrapping.
   function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
      return (v == TIME_SAT) ? v : v + TIME_W'(1);
   endfunction

endpackage

// File: rtl/race_timer_if.sv
// Race timer control/status bundle: car-position inputs and lap/race status outputs.
interface race_timer_if;
   import race_timer_pkg::*;

   logic              start;
   logic              in_finish;
   logic              in_checkpoint;
   logic [TIME_W-1:0] lap_time_bin;
   logic              lap_finished;
   logic [3:0]        lap_count;
   logic              race_running;
   logic              race_done;

   modport master (
      output start, in_finish, in_checkpoint,
      input  lap_time_bin, lap_finished, lap_count, race_running, race_done
   );

   modport slave (
      input  start, in_finish, in_checkpoint,
      output lap_time_bin, lap_finished, lap_count, race_running, race_done
   );

endinterface

// File: rtl/race_timer_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ enabled cycles;
// also usable for the on-screen race clock.
module race_timer_tick_gen #(
   parameter int CLK_HZ  = 65_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

   // A clear in the same cycle suppresses the tick so a restarted lap begins at 0.
   assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/race_timer.sv
// Per-car lap stopwatch: validates laps via checkpoint-then-finish ordering,
// counts lap time in ticks and completed laps, and ends the race after NUM_LAPS.
module race_timer
   import race_timer_pkg::*;
#(
   parameter int CLK_HZ   = 65_000_000,
   parameter int TICK_HZ  = 100,
   parameter int NUM_LAPS = 3
) (
   input logic         clk,
   input logic         rst,
   race_timer_if.slave bus
);

   localparam logic [4:0] LAPS = 5'(NUM_LAPS);

   race_state_t       state_q, state_d;
   logic              fin_q, cp_q;
   logic              fin_rise, cp_rise;
   logic              restart, lap_edge, running, tick;
   logic [TIME_W-1:0] time_q;
   logic [3:0]        count_q;
   logic              lap_pulse_q;

   assign fin_rise = bus.in_finish & ~fin_q;
   assign cp_rise  = bus.in_checkpoint & ~cp_q;
   assign running  = (state_q == ST_RUNNING) || (state_q == ST_ARMED);

   race_timer_tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (running),
      .clr  (restart | lap_edge),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fin_q   <= 1'b0;
         cp_q    <= 1'b0;
         state_q <= ST_IDLE;
      end else begin
         fin_q   <= bus.in_finish;
         cp_q    <= bus.in_checkpoint;
         state_q <= state_d;
      end
   end

   // start aborts from any state, so it is decoded ahead of the per-state rules.
   always_comb begin
      state_d  = state_q;
      restart  = 1'b0;
      lap_edge = 1'b0;
      if (bus.start) begin
         state_d = ST_RUNNING;
         restart = 1'b1;
      end else begin
         unique case (state_q)
            ST_RUNNING: if (cp_rise) state_d = ST_ARMED;
            ST_ARMED: begin
               if (fin_rise) begin
                  lap_edge = 1'b1;
                  state_d  = ({1'b0, count_q} + 5'd1 == LAPS) ? ST_DONE : ST_RUNNING;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_q      <= '0;
         count_q     <= '0;
         lap_pulse_q <= 1'b0;
      end else begin
         lap_pulse_q <= lap_edge;
         if (restart) begin
            time_q  <= '0;
            count_q <= '0;
         end else if (lap_edge) begin
            time_q  <= '0;
            count_q <= count_q + 4'd1;
         end else if (tick) begin
            time_q  <= sat_inc(time_q);
         end
      end
   end

   assign bus.lap_time_bin = time_q;
   assign bus.lap_finished = lap_pulse_q;
   assign bus.lap_count    = count_q;
   assign bus.race_running = running;
   assign bus.race_done    = (state_q == ST_DONE);

endmodule
